// File: rtl/time_setter_pkg.sv
// time_setter_pkg -- shared seconds-of-day definitions for the clock blocks.
//
// Holds the 17-bit seconds type, the day/hour/minute constants and the
// wrap-aware field helpers used by the time/alarm setter. The counter and
// alarm blocks take their seconds type and constants from here as well.
//
// Contents:
//   sec_t           17-bit seconds-of-day (0..86399)
//   edit_state_e    setter FSM states; the code is exported as edit_field
//   inc_hour()      +1 hour, wrapping at midnight, minutes/seconds kept
//   inc_min()       +1 minute, wrapping inside the hour, hour/seconds kept
//   trunc_min()     clear the seconds field (value minus value mod 60)

package time_setter_pkg;

  typedef logic [16:0] sec_t;

  localparam sec_t SEC_DAY_MAX  = 17'd86399;
  localparam sec_t SEC_PER_DAY  = 17'd86400;
  localparam sec_t SEC_PER_HOUR = 17'd3600;
  localparam sec_t SEC_PER_MIN  = 17'd60;

  // First second-of-hour whose minute field is 59 (59 * 60).
  localparam sec_t MIN59_START  = 17'd3540;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_T_HOUR = 3'd1,
    ST_T_MIN  = 3'd2,
    ST_A_HOUR = 3'd3,
    ST_A_MIN  = 3'd4
  } edit_state_e;

  // The largest legal input plus one hour still fits in 17 bits, so the
  // sum cannot overflow before the wrap test.
  function automatic sec_t inc_hour(input sec_t s);
    sec_t t;
    t = s + SEC_PER_HOUR;
    if (t > SEC_DAY_MAX) begin
      t = t - SEC_PER_DAY;
    end
    return t;
  endfunction

  function automatic sec_t inc_min(input sec_t s);
    sec_t t;
    if ((s % SEC_PER_HOUR) >= MIN59_START) begin
      t = s + SEC_PER_MIN - SEC_PER_HOUR;
    end else begin
      t = s + SEC_PER_MIN;
    end
    return t;
  endfunction

  function automatic sec_t trunc_min(input sec_t s);
    return s - (s % SEC_PER_MIN);
  endfunction

endpackage

// File: rtl/time_setter_btn_cond.sv
// btn_cond -- button conditioner: synchronizer, optional debounce, edge detect.
//
// Optional feature: define TIME_SETTER_DEBOUNCE_EN to insert a filter that
// only changes the conditioned level after DEBOUNCE_CYCLES consecutive
// synchronized samples that disagree with it. Without the macro the level
// is the two-flop synchronizer output and DEBOUNCE_CYCLES is not used by
// the datapath.
//
// Ports:
//   clock    in   system clock, posedge
//   reset    in   synchronous active-high reset
//   btn_i    in   raw asynchronous button, active-high
//   press_o  out  one-cycle pulse on a 0->1 change of the conditioned level

module btn_cond #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  logic       sync1_q;
  logic       sync2_q;
  logic       level;
  logic       prev_q;
  logic       armed_q;
  logic       armed_d;
  logic [1:0] live_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef TIME_SETTER_DEBOUNCE_EN
  localparam int CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;
  logic            filt_q;
  logic            filt_d;

  // Count consecutive samples that disagree with the current level; any
  // agreeing sample restarts the count, so short glitches never get through.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync2_q != filt_q) begin
      if (cnt_q == CntLast) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign level = filt_q;
`else
  assign level = sync2_q;
`endif

  // A zero-length filter would make the level unreachable.
  assert property (@(posedge clock) DEBOUNCE_CYCLES >= 1);

  // Presses are only accepted once the button has been seen released with
  // real post-reset samples in the synchronizer (live_q[1] set), so a button
  // held through reset cannot fire until it is released and pressed again.
  assign armed_d = armed_q | (live_q[1] & ~sync2_q & ~level);

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      live_q  <= 2'b00;
    end else begin
      prev_q  <= level;
      armed_q <= armed_d;
      live_q  <= {live_q[0], 1'b1};
    end
  end

  assign press_o = armed_q & level & ~prev_q;

endmodule

// File: rtl/time_setter.sv
// time_setter -- button-driven time and alarm setter for the digital clock.
//
// Mode steps IDLE -> T_HOUR -> T_MIN -> A_HOUR -> A_MIN -> IDLE. Entering
// T_HOUR captures the running time; leaving T_MIN strobes the edited time
// (seconds cleared) to the counter; leaving A_MIN commits the alarm time.
// Inc bumps the field being edited with in-field wrap. The alarm button
// toggles the alarm enable at any time.
//
// Optional feature: TIME_SETTER_DEBOUNCE_EN enables the debounce filter in
// each btn_cond instance (DEBOUNCE_CYCLES stable samples).
//
// Ports:
//   clock          in   system clock, posedge
//   reset          in   synchronous active-high reset
//   btn_mode       in   raw mode/advance button
//   btn_inc        in   raw increment button
//   btn_alarm      in   raw alarm enable-toggle button
//   counter_state  in   current seconds-of-day from the counter
//   set_flag       out  one-cycle load strobe to the counter
//   set_time       out  seconds-of-day to load, valid with set_flag
//   alarm_flag     out  alarm enabled level
//   alarm_time     out  committed alarm seconds-of-day
//   edit_field     out  current FSM state code, for display blinking

module time_setter
  import time_setter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_alarm,
  input  logic [16:0] counter_state,
  output logic        set_flag,
  output logic [16:0] set_time,
  output logic        alarm_flag,
  output logic [16:0] alarm_time,
  output logic [2:0]  edit_field
);

  logic mode_press;
  logic inc_press;
  logic alarm_press;

  btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clock   (clock),
    .reset   (reset),
    .btn_i   (btn_mode),
    .press_o (mode_press)
  );

  btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clock   (clock),
    .reset   (reset),
    .btn_i   (btn_inc),
    .press_o (inc_press)
  );

  btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_alarm (
    .clock   (clock),
    .reset   (reset),
    .btn_i   (btn_alarm),
    .press_o (alarm_press)
  );

  edit_state_e state_q, state_d;
  sec_t        buf_q, buf_d;
  logic        set_flag_q, set_flag_d;
  sec_t        set_time_q, set_time_d;
  logic        alarm_flag_q, alarm_flag_d;
  sec_t        alarm_time_q, alarm_time_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      buf_q        <= '0;
      set_flag_q   <= 1'b0;
      set_time_q   <= '0;
      alarm_flag_q <= 1'b0;
      alarm_time_q <= '0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      set_flag_q   <= set_flag_d;
      set_time_q   <= set_time_d;
      alarm_flag_q <= alarm_flag_d;
      alarm_time_q <= alarm_time_d;
    end
  end

  // Mode is tested before inc in every state, so a simultaneous inc press
  // is dropped. The alarm toggle sits outside the case and runs in parallel.
  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    set_flag_d   = 1'b0;
    set_time_d   = set_time_q;
    alarm_time_d = alarm_time_q;
    alarm_flag_d = alarm_flag_q ^ alarm_press;

    unique case (state_q)
      ST_IDLE: begin
        if (mode_press) begin
          buf_d   = counter_state;
          state_d = ST_T_HOUR;
        end
      end
      ST_T_HOUR: begin
        if (mode_press) begin
          state_d = ST_T_MIN;
        end else if (inc_press) begin
          buf_d = inc_hour(buf_q);
        end
      end
      ST_T_MIN: begin
        if (mode_press) begin
          set_flag_d = 1'b1;
          set_time_d = trunc_min(buf_q);
          buf_d      = alarm_time_q;
          state_d    = ST_A_HOUR;
        end else if (inc_press) begin
          buf_d = inc_min(buf_q);
        end
      end
      ST_A_HOUR: begin
        if (mode_press) begin
          state_d = ST_A_MIN;
        end else if (inc_press) begin
          buf_d = inc_hour(buf_q);
        end
      end
      ST_A_MIN: begin
        if (mode_press) begin
          alarm_time_d = trunc_min(buf_q);
          state_d      = ST_IDLE;
        end else if (inc_press) begin
          buf_d = inc_min(buf_q);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign set_flag   = set_flag_q;
  assign set_time   = set_time_q;
  assign alarm_flag = alarm_flag_q;
  assign alarm_time = alarm_time_q;
  assign edit_field = state_q;

endmodule

// File: tb/tb_time_setter.sv
module tb_time_setter;

  logic        clock;
  logic        reset;
  logic        btn_mode;
  logic        btn_inc;
  logic        btn_alarm;
  logic [16:0] counter_state;
  logic        set_flag;
  logic [16:0] set_time;
  logic        alarm_flag;
  logic [16:0] alarm_time;
  logic [2:0]  edit_field;

  int checks;
  int errors;
  int set_pulses;
  int p0;

  time_setter #(.DEBOUNCE_CYCLES(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .btn_mode      (btn_mode),
    .btn_inc       (btn_inc),
    .btn_alarm     (btn_alarm),
    .counter_state (counter_state),
    .set_flag      (set_flag),
    .set_time      (set_time),
    .alarm_flag    (alarm_flag),
    .alarm_time    (alarm_time),
    .edit_field    (edit_field)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Counts every cycle with set_flag high; a strobe longer than one cycle
  // shows up as an extra count.
  always @(negedge clock) begin
    if (set_flag) set_pulses <= set_pulses + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic press(input logic m, input logic i, input logic a);
    @(negedge clock);
    btn_mode  = m;
    btn_inc   = i;
    btn_alarm = a;
    repeat (8) @(negedge clock);
    btn_mode  = 1'b0;
    btn_inc   = 1'b0;
    btn_alarm = 1'b0;
    repeat (8) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks        = 0;
    errors        = 0;
    set_pulses    = 0;
    reset         = 1'b1;
    btn_mode      = 1'b0;
    btn_inc       = 1'b0;
    btn_alarm     = 1'b0;
    counter_state = 17'd0;
    repeat (3) @(negedge clock);
    check_val("rst_edit", edit_field, 0);
    check_val("rst_setflag", set_flag, 0);
    check_val("rst_settime", set_time, 0);
    check_val("rst_aflag", alarm_flag, 0);
    check_val("rst_atime", alarm_time, 0);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    // 12:34:56 + 1 hour, committed as 13:34:00
    counter_state = 17'd45296;
    p0 = set_pulses;
    press(1, 0, 0);
    check_val("thour_enter", edit_field, 1);
    press(0, 1, 0);
    press(1, 0, 0);
    check_val("tmin_enter", edit_field, 2);
    press(1, 0, 0);
    check_val("commit_state", edit_field, 3);
    check_val("commit_time", set_time, 48840);
    check_val("commit_pulses", set_pulses - p0, 1);
    check_val("commit_flag_low", set_flag, 0);
    press(1, 0, 0);
    check_val("amin_enter", edit_field, 4);
    press(1, 0, 0);
    check_val("idle_back", edit_field, 0);
    check_val("alarm_unchanged", alarm_time, 0);

    // inc in IDLE is ignored
    press(0, 1, 0);
    check_val("idle_inc", edit_field, 0);

    // hour wrap: 83000 + 3600 -> 200, committed as 180
    counter_state = 17'd83000;
    press(1, 0, 0);
    press(0, 1, 0);
    press(1, 0, 0);
    press(1, 0, 0);
    check_val("hour_wrap", set_time, 180);
    press(1, 0, 0);
    press(1, 0, 0);

    // minute wrap: 3599 + 1 minute -> 59, committed as 0
    counter_state = 17'd3599;
    press(1, 0, 0);
    press(1, 0, 0);
    press(0, 1, 0);
    press(1, 0, 0);
    check_val("min_wrap", set_time, 0);
    press(1, 0, 0);
    press(1, 0, 0);

    // minute without wrap: 45296 + 60 -> 45356, committed as 45300
    counter_state = 17'd45296;
    press(1, 0, 0);
    press(1, 0, 0);
    press(0, 1, 0);
    press(1, 0, 0);
    check_val("min_inc", set_time, 45300);
    press(1, 0, 0);
    press(1, 0, 0);

    // alarm edit: 7 hours from 0 -> 25200
    press(1, 0, 0);
    press(1, 0, 0);
    press(1, 0, 0);
    check_val("a_hour_enter", edit_field, 3);
    for (int k = 0; k < 7; k++) press(0, 1, 0);
    press(1, 0, 0);
    press(1, 0, 0);
    check_val("alarm_7h", alarm_time, 25200);
    check_val("alarm_idle", edit_field, 0);

    // simultaneous mode+inc in T_HOUR, then one minute on the alarm
    counter_state = 17'd45296;
    p0 = set_pulses;
    press(1, 0, 0);
    press(1, 1, 0);
    check_val("simul_state", edit_field, 2);
    press(1, 0, 0);
    check_val("simul_time", set_time, 45240);
    press(1, 0, 0);
    press(0, 1, 0);
    press(1, 0, 0);
    check_val("alarm_min", alarm_time, 25260);
    check_val("simul_pulses", set_pulses - p0, 1);

    // alarm toggle, including concurrently with a mode press
    press(0, 0, 1);
    check_val("aflag_on", alarm_flag, 1);
    press(0, 0, 1);
    check_val("aflag_off", alarm_flag, 0);
    press(1, 0, 1);
    check_val("aflag_concur", alarm_flag, 1);
    check_val("mode_concur", edit_field, 1);

    // reset while in T_MIN
    press(1, 0, 0);
    check_val("pre_rst_state", edit_field, 2);
    p0 = set_pulses;
    do_reset();
    check_val("rst_tmin_state", edit_field, 0);
    check_val("rst_tmin_pulses", set_pulses - p0, 0);
    check_val("rst_tmin_settime", set_time, 0);
    check_val("rst_tmin_aflag", alarm_flag, 0);
    check_val("rst_tmin_atime", alarm_time, 0);

    // button held through reset must not fire
    btn_mode = 1'b1;
    do_reset();
    repeat (10) @(negedge clock);
    check_val("held_no_press", edit_field, 0);
    btn_mode = 1'b0;
    repeat (10) @(negedge clock);
    press(1, 0, 0);
    check_val("held_repress", edit_field, 1);

`ifdef TIME_SETTER_DEBOUNCE_EN
    // 3-cycle inc glitch in T_HOUR is filtered
    counter_state = 17'd45296;
    do_reset();
    press(1, 0, 0);
    @(negedge clock);
    btn_inc = 1'b1;
    repeat (3) @(negedge clock);
    btn_inc = 1'b0;
    repeat (10) @(negedge clock);
    press(1, 0, 0);
    press(1, 0, 0);
    check_val("glitch_time", set_time, 45240);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
